// File: rtl/stream_mux_rr.sv
// N-to-1 registered stream multiplexer with fixed-select or round-robin
// arbitration. A one-entry output register holds each accepted beat and
// tags it with the index of the channel it came from.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    input  logic                 out_ready
);

    localparam int unsigned LAST = N - 1;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SELW-1:0]      out_src_q,   out_src_d;
    logic [SELW-1:0]      rr_ptr_q,    rr_ptr_d;

    logic                 load_en;
    logic                 gnt_found;
    logic [SELW-1:0]      gnt_idx;
    logic [SELW-1:0]      cand;
    int unsigned          pos;
    logic [WIDTH-1:0]     ch_data [N];

    // Split the flat input bus into one word per channel.
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Grant: explicit select in FIXED mode, first valid from rr_ptr in RR mode.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        pos       = 0;
        if (mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                pos = 32'(rr_ptr_q) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                cand = SELW'(pos);
                if (!gnt_found && in_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end else if ((32'(sel) < N) && in_valid[sel]) begin
            gnt_found = 1'b1;
            gnt_idx   = sel;
        end
    end

    // Handshake and next-state: load on grant, drain when empty-handed, hold on stall.
    // in_ready is masked during reset so no source sees a beat accepted that reset drops.
    always_comb begin
        load_en     = ~out_valid_q | out_ready;
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (rst_n && load_en && gnt_found) begin
            in_ready[gnt_idx] = 1'b1;
        end
        if (load_en) begin
            if (gnt_found) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[gnt_idx];
                out_src_d   = gnt_idx;
                if (mode) begin
                    rr_ptr_d = (32'(gnt_idx) == LAST) ? '0 : SELW'(32'(gnt_idx) + 1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Table-driven bench for stream_mux_rr with a beat scoreboard.
module tb_stream_mux_rr;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;
    localparam int          NV    = 31;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_src;
    logic                 out_ready;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  src;
    } beat_t;

    vec_t  vecs [NV];
    beat_t sb [$];
    beat_t last_beat;
    beat_t nb;
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  xfer;

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic o,
                                input logic [3:0] er, input logic eo);
        vec_t t;
        t.rst_n = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eo;
        return t;
    endfunction

    function automatic logic [31:0] chan_word(input int v, input int i);
        return {16'hA5A5, 8'(v), 8'(i)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //              rst mode sel vld      ordy exp_rdy  exp_ov
        vecs[0]  = mk(0, 0, 0, 4'b1111, 1, 4'b0000, 0);  // reset with all valid
        vecs[1]  = mk(0, 0, 0, 4'b1111, 1, 4'b0000, 0);
        vecs[2]  = mk(1, 0, 2, 4'b0101, 1, 4'b0100, 1);  // FIXED sel=2
        vecs[3]  = mk(1, 0, 2, 4'b0101, 1, 4'b0100, 1);
        vecs[4]  = mk(1, 0, 1, 4'b0101, 1, 4'b0000, 0);  // sel=1 not valid -> drain
        vecs[5]  = mk(1, 0, 3, 4'b0101, 1, 4'b0000, 0);  // unselected valids ignored
        vecs[6]  = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1);  // RR fairness 0,1,2,3,0,1,2,3
        vecs[7]  = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1);
        vecs[8]  = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1);
        vecs[9]  = mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1);
        vecs[10] = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1);
        vecs[11] = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1);
        vecs[12] = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1);
        vecs[13] = mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1);
        vecs[14] = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1);  // walk rr_ptr to 3
        vecs[15] = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1);
        vecs[16] = mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1);
        vecs[17] = mk(1, 1, 0, 4'b0010, 1, 4'b0010, 1);  // ptr 3 wraps to grant 1
        vecs[18] = mk(1, 1, 0, 4'b1001, 1, 4'b1000, 1);  // ptr 2 skips to 3
        vecs[19] = mk(1, 1, 0, 4'b1001, 1, 4'b0001, 1);  // ptr 0 after 3
        vecs[20] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1);  // backpressure 5 cycles
        vecs[21] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1);
        vecs[22] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1);
        vecs[23] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1);
        vecs[24] = mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1);
        vecs[25] = mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1);  // release: no bubble, ptr held at 1
        vecs[26] = mk(1, 1, 0, 4'b0000, 1, 4'b0000, 0);
        vecs[27] = mk(1, 1, 0, 4'b0100, 0, 4'b0100, 1);  // empty reg loads despite ordy=0
        vecs[28] = mk(1, 0, 0, 4'b1111, 0, 4'b0000, 1);  // mode switch while held
        vecs[29] = mk(0, 0, 0, 4'b1111, 0, 4'b0000, 0);  // reset drops held beat
        vecs[30] = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1);  // rr_ptr back to 0

        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        last_beat.data = '0;
        last_beat.src  = '0;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            rst_n     = vecs[v].rst_n;
            mode      = vecs[v].mode;
            sel       = vecs[v].sel;
            in_valid  = vecs[v].vld;
            out_ready = vecs[v].ordy;
            for (int i = 0; i < int'(N); i++) begin
                in_data[i*WIDTH +: WIDTH] = chan_word(v, i);
            end
            #3;
            check($sformatf("in_ready[v%0d]", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            xfer = vecs[v].rst_n && (vecs[v].exp_rdy != 4'b0000);
            if (xfer) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (vecs[v].exp_rdy[i]) begin
                        nb.data = chan_word(v, i);
                        nb.src  = 2'(i);
                    end
                end
                sb.push_back(nb);
            end

            @(posedge clk); #1;
            check($sformatf("out_valid[v%0d]", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            if (!vecs[v].rst_n) begin
                last_beat.data = '0;
                last_beat.src  = '0;
                sb.delete();
            end else if (xfer) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard[v%0d]: got empty queue expected a beat", v);
                end else begin
                    last_beat = sb.pop_front();
                end
            end
            check($sformatf("out_data[v%0d]", v), out_data, last_beat.data);
            check($sformatf("out_src[v%0d]", v), 32'(out_src), 32'(last_beat.src));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
